// File: rtl/lsu.sv
// lsu: memory-stage load/store unit, one outstanding access at a time.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them.
`ifndef DWIDTH
`define DWIDTH 32
`endif

module lsu (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [2:0]           req_funct3,
    input  logic [`DWIDTH-1:0]   req_addr,
    input  logic [`DWIDTH-1:0]   req_wdata,
    input  logic [4:0]           req_rd,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [`DWIDTH-1:0]   mem_req_addr,
    output logic [3:0]           mem_req_wmask,
    output logic [`DWIDTH-1:0]   mem_req_wdata,
    input  logic                 mem_resp_valid,
    input  logic [`DWIDTH-1:0]   mem_resp_data,
    output logic                 busy,
    output logic                 done,
    output logic [`DWIDTH-1:0]   done_data,
    output logic [4:0]           done_rd,
    output logic                 done_we,
    output logic                 misaligned
);

    localparam int W = `DWIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0] addr_q;
    logic [W-1:0] wdata_q;
    logic [2:0]   funct3_q;
    logic         store_q;
    logic [4:0]   rd_q;

    logic [W-1:0] data_q;
    logic [4:0]   done_rd_q;
    logic         we_q;

    logic         accept;
    logic         trap_take;
    logic         store_hs;
    logic         resp_take;

    logic         is_byte;
    logic         is_half;
    logic [1:0]   off;
    logic [1:0]   lane;
    logic [3:0]   wmask_fmt;
    logic [W-1:0] wdata_fmt;
    logic [W-1:0] shifted;
    logic [W-1:0] load_fmt;

    assign accept    = (state == IDLE) && req_valid;
    assign store_hs  = (state == REQ) && mem_req_ready && store_q;
    assign resp_take = (state == WAIT) && mem_resp_valid;

`ifdef MISALIGN_TRAP_EN
    logic mis_in;
    logic mis_q;

    always_comb begin
        mis_in = ((req_funct3[1:0] == 2'b01) && req_addr[0])
               || (req_funct3[1] && (req_addr[1:0] != 2'b00));
    end

    assign trap_take  = accept && mis_in;
    assign misaligned = mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (trap_take) begin
            mis_q <= 1'b1;
        end else if (store_hs || resp_take) begin
            mis_q <= 1'b0;
        end
    end
`else
    assign trap_take  = 1'b0;
    assign misaligned = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = trap_take ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = store_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        done          = 1'b0;
        unique case (state)
            IDLE:    req_ready = 1'b1;
            REQ:     mem_req_valid = 1'b1;
            RESP:    done = 1'b1;
            default: ;
        endcase
    end

    assign busy = ~req_ready;

    // Request fields are latched once so memory sees them stable until ready
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= 3'b000;
            store_q  <= 1'b0;
            rd_q     <= 5'd0;
        end else if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            store_q  <= req_store;
            rd_q     <= req_rd;
        end
    end

    // funct3[1:0] selects size; 010, 011, 110 and 111 all behave as a word
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        unique case (funct3_q[1:0])
            2'b00:   is_byte = 1'b1;
            2'b01:   is_half = 1'b1;
            default: ;
        endcase
    end

    assign off = addr_q[1:0];

    // Misaligned low bits are dropped here when no trap is taken
    always_comb begin
        lane      = 2'b00;
        wmask_fmt = 4'b1111;
        wdata_fmt = wdata_q;
        unique case (1'b1)
            is_byte: begin
                lane      = off;
                wmask_fmt = 4'b0001 << off;
                wdata_fmt = {4{wdata_q[7:0]}};
            end
            is_half: begin
                lane      = {off[1], 1'b0};
                wmask_fmt = 4'b0011 << {off[1], 1'b0};
                wdata_fmt = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted  = mem_resp_data >> {lane, 3'b000};
        load_fmt = shifted;
        unique case (1'b1)
            is_byte: begin
                load_fmt = {{(W-8){~funct3_q[2] & shifted[7]}},
                            shifted[7:0]};
            end
            is_half: begin
                load_fmt = {{(W-16){~funct3_q[2] & shifted[15]}},
                            shifted[15:0]};
            end
            default: ;
        endcase
    end

    assign mem_req_addr  = {addr_q[W-1:2], 2'b00};
    assign mem_req_wdata = wdata_fmt;
    assign mem_req_wmask = (mem_req_valid && store_q) ? wmask_fmt : 4'b0000;

    // Completion results, held until the next access completes
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= '0;
            done_rd_q <= 5'd0;
            we_q      <= 1'b0;
        end else if (trap_take) begin
            data_q    <= req_addr;
            done_rd_q <= req_rd;
            we_q      <= 1'b0;
        end else if (store_hs) begin
            data_q    <= '0;
            done_rd_q <= rd_q;
            we_q      <= 1'b0;
        end else if (resp_take) begin
            data_q    <= load_fmt;
            done_rd_q <= rd_q;
            we_q      <= 1'b1;
        end
    end

    assign done_data = data_q;
    assign done_rd   = done_rd_q;
    assign done_we   = we_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized self-checking bench for lsu against a byte-level model.
// Follows MISALIGN_TRAP_EN the same way the design does.
`ifndef DWIDTH
`define DWIDTH 32
`endif

module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_wmask;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        busy;
    logic        done;
    logic [31:0] done_data;
    logic [4:0]  done_rd;
    logic        done_we;
    logic        misaligned;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] last_data;
    logic [4:0]  last_rd;
    logic        last_we;

    lsu dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wmask  (mem_req_wmask),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy),
        .done           (done),
        .done_data      (done_data),
        .done_rd        (done_rd),
        .done_we        (done_we),
        .misaligned     (misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: access size in bytes, RV32I funct3 semantics
    function automatic int op_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int eff_off(input logic [2:0] f3, input logic [31:0] a);
        int n;
        int o;
        n = op_size(f3);
        o = int'(a[1:0]);
        return o - (o % n);
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % op_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = op_size(f3);
        return 4'(((1 << n) - 1) << eff_off(f3, a));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = op_size(f3);
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        logic [63:0] v;
        logic [63:0] lim;
        int n;
        n = op_size(f3);
        v = {32'd0, word} >> (8 * eff_off(f3, a));
        if (n == 4) return v[31:0];
        lim = (64'd1 << (8 * n)) - 64'd1;
        v = v & lim;
        if (f3 < 3'd4 && v[8*n-1]) v = v | ~lim;
        return v[31:0];
    endfunction

    task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input int stall, input int dly, input logic [31:0] rsp);
        logic        trap;
        logic [31:0] ea;
        logic [3:0]  em;
        logic [31:0] ew;
        logic [31:0] ed;
`ifdef MISALIGN_TRAP_EN
        trap = model_mis(f3, a);
`else
        trap = 1'b0;
`endif
        ea = a - {30'd0, a[1:0]};
        em = st ? model_mask(f3, a) : 4'b0000;
        ew = model_wdata(f3, wd);
        ed = st ? 32'd0 : model_load(f3, a, rsp);

        @(negedge clk);
        req_valid = 1'b1;
        req_store = st;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        req_rd = rd;
        vectors++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s accept: ready=%b done=%b want 1/0", tag, req_ready, done);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_store = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        req_rd = 5'($urandom);

        if (trap) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b1 || misaligned !== 1'b1 || done_we !== 1'b0
                || done_data !== a || mem_req_valid !== 1'b0 || done_rd !== rd) begin
                miscompares++;
                $display("FAIL %s trap: done=%b mis=%b we=%b data=%h mv=%b want 1/1/0/%h/0",
                         tag, done, misaligned, done_we, done_data, mem_req_valid, a);
            end
            last_data = a;
            last_rd = rd;
            last_we = 1'b0;
            return;
        end

        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            mem_req_ready = (i == stall);
            mem_resp_valid = (i < stall) ? 1'($urandom) : 1'b0;
            mem_resp_data = $urandom;
            vectors++;
            if (mem_req_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s req_state: mv=%b busy=%b done=%b want 1/1/0",
                         tag, mem_req_valid, busy, done);
            end
            vectors++;
            if (mem_req_addr !== ea || mem_req_wmask !== em) begin
                miscompares++;
                $display("FAIL %s req_addr: addr=%h mask=%b want %h/%b",
                         tag, mem_req_addr, mem_req_wmask, ea, em);
            end
            if (st) begin
                vectors++;
                if (mem_req_wdata !== ew) begin
                    miscompares++;
                    $display("FAIL %s req_wdata: got %h want %h", tag, mem_req_wdata, ew);
                end
            end
            @(posedge clk);
            #1;
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b0;
        end

        if (!st) begin
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                vectors++;
                if (done !== 1'b0 || mem_req_valid !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s wait: done=%b mv=%b busy=%b want 0/0/1",
                             tag, done, mem_req_valid, busy);
                end
            end
            @(negedge clk);
            mem_resp_valid = 1'b1;
            mem_resp_data = rsp;
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            mem_resp_data = $urandom;
        end

        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || done_we !== !st || misaligned !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done: done=%b we=%b mis=%b want 1/%b/0",
                     tag, done, done_we, misaligned, !st);
        end
        vectors++;
        if (done_data !== ed || done_rd !== rd) begin
            miscompares++;
            $display("FAIL %s result: data=%h rd=%0d want %h/%0d", tag, done_data, done_rd, ed, rd);
        end
        last_data = ed;
        last_rd = rd;
        last_we = !st;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        req_rd = 5'd0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready=%b busy=%b mv=%b want 1/0/0", req_ready, busy, mem_req_valid);
        end
        vectors++;
        if (done !== 1'b0 || done_we !== 1'b0 || misaligned !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: done=%b we=%b mis=%b want 0/0/0", done, done_we, misaligned);
        end
        vectors++;
        if (done_data !== 32'd0 || done_rd !== 5'd0 || mem_req_wmask !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_data: data=%h rd=%0d mask=%b want 0", done_data, done_rd, mem_req_wmask);
        end
        vectors++;
        if (mem_req_addr !== 32'd0 || mem_req_wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mem: addr=%h wdata=%h want 0", mem_req_addr, mem_req_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_store();
        run_op("sw", 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd3, 0, 0, 32'd0);
        run_op("sb", 1'b1, 3'd0, 32'h203, 32'h000000A5, 5'd4, 0, 0, 32'd0);
        run_op("sh", 1'b1, 3'd1, 32'h302, 32'h1234CAFE, 5'd5, 1, 0, 32'd0);
    endtask

    task automatic test_load();
        run_op("lb", 1'b0, 3'd0, 32'h101, 32'd0, 5'd6, 0, 0, 32'h12348056);
        run_op("lbu", 1'b0, 3'd4, 32'h101, 32'd0, 5'd7, 0, 0, 32'h12348056);
        run_op("lw", 1'b0, 3'd2, 32'h400, 32'd0, 5'd8, 0, 2, 32'h89ABCDEF);
        run_op("lhu", 1'b0, 3'd5, 32'h502, 32'd0, 5'd9, 0, 1, 32'h9876FFFF);
    endtask

    task automatic test_stall();
        run_op("lh_stall", 1'b0, 3'd1, 32'h102, 32'd0, 5'd10, 3, 0, 32'h80010000);
    endtask

    task automatic test_misalign();
        run_op("lw_mis", 1'b0, 3'd2, 32'h106, 32'd0, 5'd11, 0, 0, 32'hCAFEF00D);
        run_op("sh_mis", 1'b1, 3'd1, 32'h101, 32'h0000BEEF, 5'd12, 0, 0, 32'd0);
        run_op("lh_mis", 1'b0, 3'd1, 32'h203, 32'd0, 5'd13, 1, 1, 32'h8000F123);
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || done_data !== last_data || done_rd !== last_rd
                || done_we !== last_we) begin
                miscompares++;
                $display("FAIL hold: done=%b data=%h rd=%0d we=%b want 0/%h/%0d/%b",
                         done, done_data, done_rd, done_we, last_data, last_rd, last_we);
            end
        end
    endtask

    task automatic test_reset_wait();
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b0;
        req_funct3 = 3'd2;
        req_addr = 32'h600;
        req_rd = 5'd14;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wait_pre: busy=%b mv=%b want 1/0", busy, mem_req_valid);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h55AA55AA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_req_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_wait: ready=%b busy=%b done=%b mv=%b want 1/0/0/0",
                         req_ready, busy, done, mem_req_valid);
            end
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 60; k++) begin
            run_op($sformatf("rnd%0d", k), 1'($urandom), 3'($urandom_range(0, 7)),
                   $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_hold();
        test_stall();
        test_misalign();
        test_hold();
        test_reset_wait();
        test_back_to_back();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RISC-V core's memory stage. It takes the effective address produced by the execute-stage ALU, plus the store data and access type. It drives a valid/ready request to the data memory, waits for the load response, then returns a sign- or zero-extended result to writeback. Only one access is outstanding at a time, and the pipeline stalls while the unit is busy.

## Interface
Parameters:
- `DWIDTH` (macro), 32: data and address width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute stage presents a memory op.
- `req_ready`  out  1  unit can accept a new op; high only in IDLE.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  DWIDTH  effective address (ALU output).
- `req_wdata`  in  DWIDTH  store data (rs2).
- `req_rd`  in  5  destination register tag.
- `mem_req_valid`  out  1  request to data memory.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  DWIDTH  word address; bits [1:0] are always 0.
- `mem_req_wmask`  out  4  byte write mask; 0000 means a read.
- `mem_req_wdata`  out  DWIDTH  lane-aligned store data.
- `mem_resp_valid`  in  1  load data valid.
- `mem_resp_data`  in  DWIDTH  raw word read from memory.
- `busy`  out  1  equals ~req_ready; drives the pipeline stall.
- `done`  out  1  one-cycle completion pulse.
- `done_data`  out  DWIDTH  formatted load result; 0 for stores.
- `done_rd`  out  5  latched `req_rd`.
- `done_we`  out  1  1 for a completed load, 0 for a store or a trap.
- `misaligned`  out  1  qualified by `done`; the access trapped.

## Operation
- FSM has four states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch addr, wdata, funct3, store and rd.
  - Misaligned access with `MISALIGN_TRAP_EN` defined: go to RESP with the trap flag set.
  - Otherwise go to REQ.
- REQ:
  - `mem_req_valid`=1 and all `mem_req_*` outputs are held stable until `mem_req_ready`.
  - On handshake, a store goes to RESP and a load goes to WAIT.
- WAIT:
  - On `mem_resp_valid`, register the formatted data and go to RESP.
  - `mem_resp_valid` is ignored in every other state.
- RESP: `done`=1 for one cycle, then IDLE.
- Store lane formatting, with o = addr[1:0]:
  - SB: wdata={4{wdata[7:0]}}, wmask=0001<<o.
  - SH: wdata={2{wdata[15:0]}}, wmask=0011<<{o[1],0}.
  - SW: wdata=wdata, wmask=1111.
- Load formatting:
  - Shift the word right by 8*o.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Any other funct3 value is treated as W.
- Misalignment rule: H with o[0]=1, or W with o!=0.

## Timing
- Reset values:
  - State = IDLE; `req_ready`=1; `busy`=0.
  - `mem_req_valid`=0; `mem_req_wmask`=0.
  - `done`=0; `done_we`=0; `misaligned`=0.
  - `done_data`=0; `done_rd`=0; `mem_req_addr`=0; `mem_req_wdata`=0.
- Accept at cycle 0. REQ starts at cycle 1.
- Store with `mem_req_ready` high at cycle 1: `done` at cycle 2. Each cycle of `mem_req_ready` low adds one cycle.
- Load: the response arrives no earlier than the cycle after the handshake. `done` follows one cycle after `mem_resp_valid`. Best case is `done` at cycle 3.
- Trap: `done` at cycle 1 with no memory request issued.
- Back-to-back: a new op can be accepted in the cycle after `done`.
- Reset asserted in any state:
  - Next cycle is IDLE with `mem_req_valid`=0.
  - A pending response arriving later is dropped.
- All `done_*` outputs are valid only while `done`=1 and hold their value otherwise.

## Configuration
- Macro: `MISALIGN_TRAP_EN`.
- Defined:
  - A misaligned access issues no memory request.
  - `done`=1, `misaligned`=1, `done_we`=0, `done_data`=latched address.
- Undefined:
  - Offending low address bits are cleared before lane formatting (H: o[0]=0; W: o=00).
  - The access proceeds normally.
  - `misaligned` is tied to 0.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, `mem_req_ready` high -> cycle 1: addr 0x100, wmask 1111, wdata 0xDEADBEEF; cycle 2: `done`=1, `done_we`=0.
- SB addr 0x203, wdata 0x000000A5 -> wmask 1000, wdata 0xA5A5A5A5, addr 0x200.
- LB addr 0x101, response 0x12348056, resp one cycle after handshake -> `done` at cycle 3, `done_data` 0xFFFFFF80, `done_we`=1; LBU of the same access -> 0x00000080.
- LH addr 0x102, response 0x80010000, `mem_req_ready` low for 3 cycles -> request held stable throughout, `done_data` 0xFFFF8001.
- LW addr 0x106:
  - Macro defined -> `done` at cycle 1, `misaligned`=1, `done_data` 0x106, no `mem_req_valid`.
  - Macro undefined -> read of word 0x104.
- Reset pulsed during WAIT, then `mem_resp_valid` -> unit returns to IDLE, `req_ready`=1, no `done`.
